gate_net_score_accum: RTL
=========================

// Module: gate_net_score_accum
// PURPOSE
// - Downstream scoring stage for a combinational learned gate network (MNIST-scaling flow).
// - Consumes one prediction vector per accepted handshake and compares it with the expected label vector.
// - Counts total samples and exact-match samples over a run of N_SAMPLES.
// - Reports the results to the experiment harness when the run ends.
// PARAMETERS
// - OUT_W      2   width of the prediction/label vector (gate-net out_bits width)
// - CNT_W      16  width of every counter
// - N_SAMPLES  4   samples per run; 1 <= N_SAMPLES <= 2**CNT_W-1
// PORTS
// - clk          in   1              rising-edge clock
// - rst          in   1              asynchronous, active-high reset
// - start        in   1              single-cycle request to begin a run
// - pred_valid   in   1              pred_bits/exp_bits carry a sample
// - pred_ready   out  1              stage accepts a sample this cycle
// - pred_bits    in   OUT_W          gate-net out_bits for the sample
// - exp_bits     in   OUT_W          expected label bits for the sample
// - busy         out  1              run in progress
// - done         out  1              run complete; results stable
// - total_cnt    out  CNT_W          samples accepted in the current/last run
// - correct_cnt  out  CNT_W          samples where pred_bits == exp_bits
// - all_correct  out  1              done && correct_cnt == total_cnt
// - bit_err_cnt  out  OUT_W*CNT_W    per-bit mismatch counts; slice i = bit i (only with GNS_BIT_ERR_EN)
// BEHAVIOUR
// - Reset: state IDLE; all counters 0; pred_ready, busy, done and all_correct are 0.
// - FSM states: IDLE, RUN, DONE. pred_ready = (state==RUN). busy = (state==RUN). done = (state==DONE).
// - IDLE: start -> RUN next cycle; all counters clear on the same edge.
// - RUN: a sample is accepted when pred_valid && pred_ready.
//   - On accept, total_cnt += 1.
//   - On accept, correct_cnt += 1 when every bit of pred_bits equals exp_bits.
//   - Updated counts are visible 1 cycle after the accepting edge.
// - RUN -> DONE on the edge that accepts sample number N_SAMPLES. done is high the next cycle and pred_ready drops that same cycle.
// - start while in RUN: ignored. The run continues and counters are kept.
// - DONE: state and counts hold until start. start -> RUN with counters cleared, exactly as from IDLE.
// - pred_valid while pred_ready=0: ignored. No counter changes.
// - Counters saturate at 2**CNT_W-1 and never wrap. With a legal N_SAMPLES, saturation is unreachable; it is a safety rule only.
// - Comparison is purely bitwise equality over OUT_W bits. No X handling is required.
// - rst asserted mid-run: immediate return to the reset state. Partial counts are discarded.
// - No combinational path from pred_valid to pred_ready.
// CONFIGURATION
// - GNS_BIT_ERR_EN defined:
//   - One CNT_W counter per output bit, incremented on accept when pred_bits[i] != exp_bits[i].
//   - Counters clear with the other counters and saturate at 2**CNT_W-1.
//   - bit_err_cnt is driven from these counters.
// - GNS_BIT_ERR_EN undefined:
//   - bit_err_cnt is tied to 0.
//   - No per-bit counter logic is present.
//   - All other behaviour is unchanged.
// TESTING
// - Perfect run: rst, start; 4 samples with pred==exp, pred_valid held high
//   -> done 1 cycle after the 4th accept; total=4, correct=4, all_correct=1.
// - Mismatch run: pred/exp = 00/00, 01/11, 10/10, 11/01
//   -> total=4, correct=2, all_correct=0.
//   - With GNS_BIT_ERR_EN: bit_err_cnt[bit0]=0, bit_err_cnt[bit1]=2.
// - Bubbles: pred_valid toggled 1,0,0,1,1,0,1
//   -> only the 4 valid cycles are counted; done after the 4th.
// - Control corner cases:
//   - start pulsed mid-run -> counts continue without clearing.
//   - start in DONE -> counters read 0 on the next cycle, busy=1.
// - Reset mid-run: rst asserted after 2 accepts -> outputs 0 in the same cycle.
//   - A following full run then reports total=4.
// - Backpressure: pred_valid=1 in IDLE and DONE -> pred_ready=0 and counts unchanged.

Source files
------------

// File: rtl/gate_net_score_accum.sv
// Scores gate-net predictions against labels over a run of N_SAMPLES; optional per-bit error counters under GNS_BIT_ERR_EN.
// Latency: counts visible 1 cycle after the accepting edge; done the cycle after the last accept.
// Backpressure: pred_ready is high only while running and depends on registered state alone.
module gate_net_score_accum #(
    parameter int OUT_W     = 2,
    parameter int CNT_W     = 16,
    parameter int N_SAMPLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pred_valid,
    output logic                   pred_ready,
    input  logic [OUT_W-1:0]       pred_bits,
    input  logic [OUT_W-1:0]       exp_bits,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       total_cnt,
    output logic [CNT_W-1:0]       correct_cnt,
    output logic                   all_correct,
    output logic [OUT_W*CNT_W-1:0] bit_err_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_SAMPLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] correct_q, correct_d;
    logic             accept;
    logic             clear;

    assign accept = pred_valid && (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (accept && (total_q == N_LAST)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pred_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            RUN:     begin pred_ready = 1'b1; busy = 1'b1; end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counters saturate rather than wrap; unreachable with a legal N_SAMPLES.
    always_comb begin
        total_d   = total_q;
        correct_d = correct_q;
        if (clear) begin
            total_d   = '0;
            correct_d = '0;
        end else if (accept) begin
            if (total_q != CNT_MAX) begin
                total_d = total_q + 1'b1;
            end
            if ((pred_bits == exp_bits) && (correct_q != CNT_MAX)) begin
                correct_d = correct_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q   <= '0;
            correct_q <= '0;
        end else begin
            total_q   <= total_d;
            correct_q <= correct_d;
        end
    end

    assign total_cnt   = total_q;
    assign correct_cnt = correct_q;
    assign all_correct = done && (correct_q == total_q);

`ifdef GNS_BIT_ERR_EN
    logic [CNT_W-1:0] bit_err_q [OUT_W];
    logic [CNT_W-1:0] bit_err_d [OUT_W];

    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            bit_err_d[i] = bit_err_q[i];
            if (clear) begin
                bit_err_d[i] = '0;
            end else if (accept && (pred_bits[i] != exp_bits[i]) && (bit_err_q[i] != CNT_MAX)) begin
                bit_err_d[i] = bit_err_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_W; i++) begin
                bit_err_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                bit_err_q[i] <= bit_err_d[i];
            end
        end
    end

    always_comb begin
        bit_err_cnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            bit_err_cnt[i*CNT_W +: CNT_W] = bit_err_q[i];
        end
    end
`else
    assign bit_err_cnt = '0;
`endif

endmodule
